// File: rtl/d_flip_flop_pkg.sv
// Shared constants and elaboration helpers for the d_flip_flop register family.
package d_flip_flop_pkg;

  localparam int DFF_MAX_WIDTH = 1024;

  function automatic bit dff_width_ok(input int width);
    return (width >= 1) && (width <= DFF_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/dff_bit_cell.sv
// Single-bit rising-edge flop with asynchronous active-high reset to a tied value.
module dff_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignment so every cell samples
  // its input before any cell updates, whatever order the simulator runs them in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= rst_val;
    else     q <= d;
  end

endmodule

// File: rtl/d_flip_flop.sv
// Parameterisable D register with async active-high reset to RESET_VALUE.
// Optional change-detect output enabled by defining D_FLIP_FLOP_CHANGE_DET_EN.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
  output logic             changed,
`endif
  output logic [WIDTH-1:0] q
);

  if (!dff_width_ok(WIDTH)) begin : g_bad_width
    $error("d_flip_flop: WIDTH out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VALUE[i]),
      .d       (d[i]),
      .q       (q[i])
    );
  end

`ifdef D_FLIP_FLOP_CHANGE_DET_EN
  logic [WIDTH-1:0] shadow;

  // Shadow trails q by one edge; both reset to RESET_VALUE, so changed is
  // low during reset and the first edge compares against RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_shadow
    dff_bit_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VALUE[i]),
      .d       (q[i]),
      .q       (shadow[i])
    );
  end

  assign changed = |(q ^ shadow);
`endif

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: a 1-bit default instance and an 8-bit
// instance resetting to 8'hA5 share clk/rst and are driven from one vector table.
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;
  logic       chg1;
  logic       chg8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_flip_flop u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .d       (d1),
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
    .changed (chg1),
`endif
    .q       (q1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .d       (d8),
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
    .changed (chg8),
`endif
    .q       (q8)
  );

`ifndef D_FLIP_FLOP_CHANGE_DET_EN
  assign chg1 = 1'b0;
  assign chg8 = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic       q1_pre;
    logic       q1_post;
    logic [7:0] q8_pre;
    logic [7:0] q8_post;
    logic       chg_pre;
    logic       chg_post;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    logic [3:0] cd_d;
    logic [3:0] cd_exp;

    // Inputs applied at the falling edge; "pre" is sampled 1 ns later (shows
    // async reset and between-edge stability), "post" 1 ns after the next rising edge.
    //            rst   d1    d8     q1pre q1post q8pre  q8post chgpre chgpost
    vecs[0] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h3C, 8'hFF, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'hFF, 8'h0F, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b0};

    rst = 1'b1;
    d1  = 1'b0;
    d8  = 8'h00;

    #1;
    check("powerup_q1", {7'b0, q1}, 8'h00);
    check("powerup_q8", q8, 8'hA5);
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
    check("powerup_chg", {7'b0, chg1}, 8'h00);
`endif
    @(posedge clk); #1;
    check("reset_edge_ignored_q1", {7'b0, q1}, 8'h00);
    check("reset_edge_ignored_q8", q8, 8'hA5);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      d1  = vecs[i].d1;
      d8  = vecs[i].d8;
      #1;
      check($sformatf("vec%0d_q1_pre", i), {7'b0, q1}, {7'b0, vecs[i].q1_pre});
      check($sformatf("vec%0d_q8_pre", i), q8, vecs[i].q8_pre);
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
      check($sformatf("vec%0d_chg_pre", i), {7'b0, chg1}, {7'b0, vecs[i].chg_pre});
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d_q1_post", i), {7'b0, q1}, {7'b0, vecs[i].q1_post});
      check($sformatf("vec%0d_q8_post", i), q8, vecs[i].q8_post);
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
      check($sformatf("vec%0d_chg_post", i), {7'b0, chg1}, {7'b0, vecs[i].chg_post});
`endif
    end

    // Glitches on d between edges must not reach q.
    @(negedge clk);
    d1 = 1'b0; d8 = 8'h12; #1;
    d1 = 1'b1; d8 = 8'hED; #1;
    d1 = 1'b0; d8 = 8'h00; #1;
    check("glitch_q1_stable", {7'b0, q1}, 8'h01);
    check("glitch_q8_stable", q8, 8'hC3);
    @(posedge clk); #1;
    check("after_glitch_q1", {7'b0, q1}, 8'h00);
    check("after_glitch_q8", q8, 8'h00);
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
    check("after_glitch_chg8", {7'b0, chg8}, 8'h01);
`endif

    // Mid-cycle reset, then change-detect sequence d = 1,1,0,0.
    @(negedge clk);
    rst = 1'b1; d1 = 1'b1; d8 = 8'hFF; #1;
    check("midreset_q1", {7'b0, q1}, 8'h00);
    check("midreset_q8", q8, 8'hA5);
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
    check("midreset_chg", {7'b0, chg1}, 8'h00);
`endif
    cd_d   = 4'b0011;  // bit k is the d value for step k
    cd_exp = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      d1  = cd_d[k];
      @(posedge clk); #1;
      check($sformatf("chgseq%0d_q1", k), {7'b0, q1}, {7'b0, cd_d[k]});
`ifdef D_FLIP_FLOP_CHANGE_DET_EN
      check($sformatf("chgseq%0d_chg", k), {7'b0, chg1}, {7'b0, cd_exp[k]});
`endif
    end
    check("chgseq_q8", q8, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
